rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, at least 2).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have localparam AW = $clog2(NREG).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, NRD*AW bits: read addresses; port i occupies bits [i*AW +: AW].
REQ-008 The block SHALL have port rd_data, output, NRD*XLEN bits: combinational read data, one XLEN slice per read port.
REQ-009 The block SHALL have port rd_busy, output, NRD bits: pending-write flag of each addressed register.
REQ-010 The block SHALL have port iss_en, input, 1 bit: issue request that marks a destination register pending.
REQ-011 The block SHALL have port iss_addr, input, AW bits: destination register of the issue.
REQ-012 The block SHALL have port iss_ready, output, 1 bit: the issue is accepted this cycle.
REQ-013 The block SHALL have port wb_en, input, 1 bit: writeback enable.
REQ-014 The block SHALL have port wb_addr, input, AW bits: writeback register.
REQ-015 The block SHALL have port wb_data, input, XLEN bits: writeback data.
REQ-016 The block SHALL have port flush, input, 1 bit: clear all pending flags.
REQ-017 The block SHALL have port busy_cnt, output, AW+1 bits: registered count of pending registers.

Function
REQ-018 Register 0 SHALL always read 0 with rd_busy 0; writebacks and issues to address 0 SHALL be ignored.
REQ-019 iss_ready SHALL equal ~busy[iss_addr] | (iss_addr==0), combinationally; issue is accepted when iss_en & iss_ready.
REQ-020 An accepted issue to a nonzero register SHALL set busy for that register at the next edge.
REQ-021 When wb_en=1 and wb_addr!=0, the block SHALL write wb_data and clear busy[wb_addr] at the next edge.
REQ-022 When a writeback and an accepted issue target the same register in the same cycle, the data SHALL be written and busy SHALL stay set (issue wins).
REQ-023 flush=1 SHALL clear every busy bit at the next edge without altering data; an issue in the same cycle SHALL be dropped; a writeback in the same cycle SHALL still write data.
REQ-024 busy_cnt SHALL track the number of set busy bits exactly, updated in the same edge as the bits, and never wrap.
REQ-025 Without bypass, written data SHALL become readable one cycle after the write.

Reset
REQ-026 While rst_n=0, the block SHALL immediately clear all registers, all busy bits and busy_cnt; every output SHALL read 0, except iss_ready, which SHALL read 1.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight issue or writeback in that cycle.

Configuration
REQ-028 With macro RF_SCOREBOARD_BYPASS_EN defined, a read port whose address equals a nonzero wb_addr while wb_en=1 SHALL return wb_data and rd_busy=0 in the same cycle.
REQ-029 Without RF_SCOREBOARD_BYPASS_EN, such a read SHALL return the stored value and the stored busy bit.

Structure
REQ-030 Package rf_pkg SHALL hold default XLEN/NREG constants, the AW derivation function and the zero-register index constant.
REQ-031 The busy table and its counter SHALL be a sub-module named rf_busy_tbl; the data array, read muxing and bypass SHALL stay in rf_scoreboard.

Verification
REQ-032 Reset, then read all addresses -> rd_data 0, rd_busy 0, busy_cnt 0, iss_ready 1.
REQ-033 Issue to x5, then issue x5 again -> iss_ready 0 on the second cycle and busy_cnt 1; writeback x5=0xDEADBEEF -> next cycle rd_data 0xDEADBEEF, rd_busy 0, busy_cnt 0.
REQ-034 Same-cycle issue and writeback to x7 with 0x12345678 -> x7 reads 0x12345678, busy[7]=1, busy_cnt unchanged+1.
REQ-035 Writeback x0=0xFFFFFFFF and issue x0 -> x0 reads 0, busy_cnt 0.
REQ-036 Issue x1, x2, x3, then flush with a same-cycle issue to x4 -> busy_cnt 0, x4 not busy.
REQ-037 Writeback x9=0xA5A5A5A5 while reading x9 -> with RF_SCOREBOARD_BYPASS_EN, same-cycle rd_data 0xA5A5A5A5; without it, the old value.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the register-file scoreboard.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   ZERO_REG            : index of the hardwired-zero register
//   addr_w()            : address width for a given register count
package rf_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int ZERO_REG = 0;
   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/rf_busy_tbl.sv
// rf_busy_tbl: pending-write (busy) table with a registered pending count.
//   clk, rst_n          : clock, asynchronous active-low reset
//   iss_en, iss_addr    : issue request marking a destination pending
//   iss_ready           : issue accepted this cycle (target not busy, or x0)
//   wb_en, wb_addr      : writeback clearing a pending flag
//   flush               : clear every pending flag, drop same-cycle issue
//   busy                : per-register pending flags
//   busy_cnt            : number of set pending flags
module rf_busy_tbl
   import rf_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = addr_w(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_addr,
   output logic            iss_ready,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic            flush,
   output logic [NREG-1:0] busy,
   output logic [AW:0]     busy_cnt
);
   logic [NREG-1:0] busy_d;
   logic [AW:0]     cnt_d;
   logic            acc;
   logic            clr;
   assign iss_ready = ~busy[iss_addr] | (iss_addr == AW'(ZERO_REG));
   // An accepted issue always targets a non-busy register, so acc and clr can
   // never both change the count for the same register: issue-wins is free.
   always_comb begin
      acc    = iss_en & iss_ready & (iss_addr != AW'(ZERO_REG)) & ~flush;
      clr    = wb_en & (wb_addr != AW'(ZERO_REG)) & busy[wb_addr];
      busy_d = busy;
      if (clr) busy_d[wb_addr] = 1'b0;
      if (acc) busy_d[iss_addr] = 1'b1;
      if (flush) busy_d = '0;
      cnt_d  = flush ? '0 : busy_cnt + (AW+1)'(acc) - (AW+1)'(clr);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_d;
         busy_cnt <= cnt_d;
      end
   end
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with per-register pending-write scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_addr/rd_data     : NRD combinational read ports, port i at slice i
//   rd_busy             : pending flag of each read port's register
//   iss_en/iss_addr     : issue request, iss_ready = accepted this cycle
//   wb_en/wb_addr/wb_data : writeback, clears the pending flag
//   flush               : clear all pending flags
//   busy_cnt            : registered count of pending registers
// Optional macro RF_SCOREBOARD_BYPASS_EN forwards a same-cycle writeback to
// matching read ports (data = wb_data, busy = 0).
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
   output logic [NRD*XLEN-1:0]    rd_data,
   output logic [NRD-1:0]         rd_busy,
   input  logic                   iss_en,
   input  logic [$clog2(NREG)-1:0] iss_addr,
   output logic                   iss_ready,
   input  logic                   wb_en,
   input  logic [$clog2(NREG)-1:0] wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   flush,
   output logic [$clog2(NREG):0]  busy_cnt
);
   localparam int AW = $clog2(NREG);
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic            wr;
   assign wr = wb_en & (wb_addr != AW'(ZERO_REG));
   rf_busy_tbl #(.NREG(NREG), .AW(AW)) u_busy (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_ready(iss_ready),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .flush    (flush),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );
   // Register 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs <= '{default: '0};
      else if (wr) regs[wb_addr] <= wb_data;
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[i*AW +: AW];
`ifdef RF_SCOREBOARD_BYPASS_EN
      // Gated by rst_n so outputs read zero while reset is held.
      logic hit;
      assign hit = rst_n & wr & (a == wb_addr);
      assign rd_data[i*XLEN +: XLEN] = hit ? wb_data : regs[a];
      assign rd_busy[i] = ~hit & busy[a];
`else
      assign rd_data[i*XLEN +: XLEN] = regs[a];
      assign rd_busy[i] = busy[a];
`endif
   end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;
   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                iss_ready;
   logic                wb_en;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                flush;
   logic [AW:0]         busy_cnt;
   int vectors = 0;
   int miscompares = 0;
   rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_ready(iss_ready),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .flush    (flush),
      .busy_cnt (busy_cnt)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      iss_en = 0; iss_addr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask
   task automatic test_reset();
      rst_n = 0;
      idle();
      rd_addr = '0;
      #3;
      for (int a = 0; a < NREG; a += 2) begin
         rd_addr = {AW'(a + 1), AW'(a)};
         #1;
         vectors++;
         if (rd_data !== '0 || rd_busy !== '0) begin
            miscompares++;
            $display("FAIL reset_read addr=%0d: got data=%h busy=%b, expected 0/0", a, rd_data, rd_busy);
         end
      end
      vectors++;
      if (busy_cnt !== 0 || iss_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got cnt=%0d ready=%b, expected 0/1", busy_cnt, iss_ready);
      end
      tick();
      rst_n = 1;
      tick();
   endtask
   task automatic test_issue_wb();
      iss_en = 1; iss_addr = 5; rd_addr = {AW'(0), AW'(5)};
      #1;
      vectors++;
      if (iss_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_x5_first: got ready=%b, expected 1", iss_ready);
      end
      tick();
      vectors++;
      if (iss_ready !== 1'b0 || busy_cnt !== 1 || rd_busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_x5_second: got ready=%b cnt=%0d busy=%b, expected 0/1/1", iss_ready, busy_cnt, rd_busy[0]);
      end
      tick();
      vectors++;
      if (busy_cnt !== 1) begin
         miscompares++;
         $display("FAIL issue_x5_refused: got cnt=%0d, expected 1", busy_cnt);
      end
      iss_en = 0; wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || busy_cnt !== 0) begin
         miscompares++;
         $display("FAIL wb_x5: got data=%h busy=%b cnt=%0d, expected deadbeef/0/0", rd_data[31:0], rd_busy[0], busy_cnt);
      end
   endtask
   task automatic test_same_cycle();
      rd_addr = {AW'(7), AW'(0)};
      iss_en = 1; iss_addr = 7; wb_en = 1; wb_addr = 7; wb_data = 32'h12345678;
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data[63:32] !== 32'h12345678 || rd_busy[1] !== 1'b1 || busy_cnt !== 1) begin
         miscompares++;
         $display("FAIL same_cycle_x7: got data=%h busy=%b cnt=%0d, expected 12345678/1/1", rd_data[63:32], rd_busy[1], busy_cnt);
      end
      wb_en = 1; wb_addr = 7; wb_data = 32'h12345678;
      tick();
      idle();
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b0 || busy_cnt !== 0) begin
         miscompares++;
         $display("FAIL clear_x7: got busy=%b cnt=%0d, expected 0/0", rd_busy[1], busy_cnt);
      end
   endtask
   task automatic test_zero_reg();
      rd_addr = '0;
      wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
      #1;
      vectors++;
      if (iss_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL x0_ready: got %b, expected 1", iss_ready);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data !== '0 || rd_busy !== '0 || busy_cnt !== 0) begin
         miscompares++;
         $display("FAIL x0_write: got data=%h busy=%b cnt=%0d, expected 0/0/0", rd_data, rd_busy, busy_cnt);
      end
   endtask
   task automatic test_flush();
      for (int r = 1; r <= 3; r++) begin
         iss_en = 1; iss_addr = AW'(r);
         tick();
      end
      idle();
      vectors++;
      if (busy_cnt !== 3) begin
         miscompares++;
         $display("FAIL three_issues: got cnt=%0d, expected 3", busy_cnt);
      end
      flush = 1; iss_en = 1; iss_addr = 4;
      tick();
      idle();
      rd_addr = {AW'(5), AW'(4)};
      #1;
      vectors++;
      if (busy_cnt !== 0 || rd_busy !== 2'b00) begin
         miscompares++;
         $display("FAIL flush: got cnt=%0d busy=%b, expected 0/00", busy_cnt, rd_busy);
      end
      vectors++;
      if (rd_data[63:32] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL flush_keeps_data: got %h, expected deadbeef", rd_data[63:32]);
      end
   endtask
   task automatic test_bypass();
      wb_en = 1; wb_addr = 9; wb_data = 32'h11111111;
      tick();
      idle();
      iss_en = 1; iss_addr = 9;
      tick();
      idle();
      rd_addr = {AW'(9), AW'(0)};
      wb_en = 1; wb_addr = 9; wb_data = 32'hA5A5A5A5;
      #1;
      vectors++;
`ifdef RF_SCOREBOARD_BYPASS_EN
      if (rd_data[63:32] !== 32'hA5A5A5A5 || rd_busy[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL bypass_x9: got data=%h busy=%b, expected a5a5a5a5/0", rd_data[63:32], rd_busy[1]);
      end
`else
      if (rd_data[63:32] !== 32'h11111111 || rd_busy[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL no_bypass_x9: got data=%h busy=%b, expected 11111111/1", rd_data[63:32], rd_busy[1]);
      end
`endif
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data[63:32] !== 32'hA5A5A5A5 || rd_busy[1] !== 1'b0 || busy_cnt !== 0) begin
         miscompares++;
         $display("FAIL after_wb_x9: got data=%h busy=%b cnt=%0d, expected a5a5a5a5/0/0", rd_data[63:32], rd_busy[1], busy_cnt);
      end
   endtask
   task automatic test_reset_midop();
      iss_en = 1; iss_addr = 10;
      tick();
      iss_en = 1; iss_addr = 11; wb_en = 1; wb_addr = 12; wb_data = 32'h0BADF00D;
      rd_addr = {AW'(12), AW'(10)};
      #2;
      rst_n = 0;
      #1;
      vectors++;
      if (busy_cnt !== 0 || rd_busy !== 2'b00 || iss_ready !== 1'b1 || rd_data !== '0) begin
         miscompares++;
         $display("FAIL midop_reset: got cnt=%0d busy=%b ready=%b data=%h, expected 0/00/1/0", busy_cnt, rd_busy, iss_ready, rd_data);
      end
      tick();
      idle();
      rst_n = 1;
      rd_addr = {AW'(9), AW'(12)};
      tick();
      vectors++;
      if (rd_data !== '0 || busy_cnt !== 0) begin
         miscompares++;
         $display("FAIL midop_discard: got data=%h cnt=%0d, expected 0/0", rd_data, busy_cnt);
      end
   endtask
   initial begin
      test_reset();
      test_issue_wb();
      test_same_cycle();
      test_zero_reg();
      test_flush();
      test_bypass();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
